// File: rtl/ase_simkill_ctrl_pkg.sv
// Shared types and mode encodings for the ASE simulation-kill controller.
package ase_simkill_ctrl_pkg;

  localparam logic [2:0] ASE_MODE_DAEMON  = 3'd1;
  localparam logic [2:0] ASE_MODE_TIMEOUT = 3'd2;
  localparam logic [2:0] ASE_MODE_SW      = 3'd3;
  localparam logic [2:0] ASE_MODE_REGRESS = 3'd4;

  typedef enum logic [2:0] {
    StUncfg    = 3'd0,
    StArmed    = 3'd1,
    StRunning  = 3'd2,
    StIdleWait = 3'd3,
    StDrain    = 3'd4,
    StKill     = 3'd5
  } simkill_state_t;

  typedef enum logic [1:0] {
    ReasonNone    = 2'd0,
    ReasonTimeout = 2'd1,
    ReasonSw      = 2'd2,
    ReasonRegress = 2'd3
  } kill_reason_t;

  function automatic logic mode_valid(input logic [2:0] mode);
    return (mode >= ASE_MODE_DAEMON) && (mode <= ASE_MODE_REGRESS);
  endfunction

endpackage

// File: rtl/ase_tick_prescaler.sv
// Free-running divider: one tick pulse every TICKS_PER_UNIT enabled cycles.
module ase_tick_prescaler #(
  parameter int unsigned TICKS_PER_UNIT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_UNIT - 1);

  logic [CW-1:0] cnt_q;

  // Clear wins over a coincident wrap so activity always restarts the unit.
  assign tick = enable && !clear && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/ase_simkill_ctrl.sv
// Decides when the ASE simulation ends from run config, SW session pulses and link activity.
module ase_simkill_ctrl
  import ase_simkill_ctrl_pkg::*;
#(
  parameter int unsigned TICKS_PER_UNIT = 1000,
  parameter int unsigned DRAIN_CYCLES   = 16,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [2:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic [CNT_W-1:0] cfg_num_tests,
  input  logic             sw_session_start,
  input  logic             sw_session_end,
  input  logic             sw_simkill_req,
  input  logic             link_activity,
  output logic             simkill_req,
  output logic [1:0]       kill_reason,
  output logic [CNT_W-1:0] sessions_done,
  output logic             cfg_err,
  output logic [2:0]       state_o
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) + 1 : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  simkill_state_t   state_q, state_d;
  kill_reason_t     reason_q, reason_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] sessions_q, sessions_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             cfg_err_q, cfg_err_d;
  logic             simkill_q;

  logic             presc_clear;
  logic             tick;
  logic [CNT_W-1:0] sess_inc;
  logic [CNT_W-1:0] target;

  ase_tick_prescaler #(
    .TICKS_PER_UNIT(TICKS_PER_UNIT)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (presc_clear),
    .enable(state_q == StIdleWait),
    .tick  (tick)
  );

  assign sess_inc = (sessions_q == '1) ? sessions_q : sessions_q + CNT_W'(1);
  // A zero test count still means "kill after the first session".
  assign target   = (num_q == '0) ? CNT_W'(1) : num_q;

  always_comb begin
    state_d     = state_q;
    reason_d    = reason_q;
    mode_d      = mode_q;
    timeout_d   = timeout_q;
    num_d       = num_q;
    sessions_d  = sessions_q;
    idle_d      = idle_q;
    drain_d     = drain_q;
    cfg_err_d   = cfg_err_q;
    presc_clear = 1'b0;

    case (state_q)
      StUncfg: begin
        if (cfg_valid) begin
          mode_d    = mode_valid(cfg_mode) ? cfg_mode : ASE_MODE_DAEMON;
          cfg_err_d = !mode_valid(cfg_mode);
          timeout_d = cfg_timeout;
          num_d     = cfg_num_tests;
          state_d   = StArmed;
        end
      end
      StArmed: begin
        if (sw_session_start) state_d = StRunning;
      end
      StRunning: begin
        // A start arriving with the end is dropped: the end rule alone picks the next state.
        if (sw_session_end) begin
          sessions_d = sess_inc;
          case (mode_q)
            ASE_MODE_TIMEOUT: begin
              state_d     = StIdleWait;
              idle_d      = '0;
              presc_clear = 1'b1;
            end
            ASE_MODE_SW: begin
              state_d  = StDrain;
              reason_d = ReasonSw;
              drain_d  = '0;
            end
            ASE_MODE_REGRESS: begin
              if (sess_inc >= target) begin
                state_d  = StDrain;
                reason_d = ReasonRegress;
                drain_d  = '0;
              end else begin
                state_d = StArmed;
              end
            end
            default: state_d = StArmed;
          endcase
        end
      end
      StIdleWait: begin
        if (sw_session_start) begin
          state_d = StRunning;
        end else if (idle_q == timeout_q) begin
          state_d  = StDrain;
          reason_d = ReasonTimeout;
          drain_d  = '0;
        end else if (link_activity) begin
          idle_d      = '0;
          presc_clear = 1'b1;
        end else if (tick) begin
          idle_d = idle_q + CNT_W'(1);
        end
      end
      StDrain: begin
        if (drain_q == DRAIN_LAST) state_d = StKill;
        else drain_d = drain_q + DW'(1);
      end
      StKill: ;
      default: state_d = StUncfg;
    endcase

    // Explicit SW kill overrides any transition; DRAIN keeps its original reason.
    if (sw_simkill_req &&
        (state_q == StArmed || state_q == StRunning || state_q == StIdleWait)) begin
      state_d  = StDrain;
      reason_d = ReasonSw;
      drain_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StUncfg;
      reason_q   <= ReasonNone;
      mode_q     <= '0;
      timeout_q  <= '0;
      num_q      <= '0;
      sessions_q <= '0;
      idle_q     <= '0;
      drain_q    <= '0;
      cfg_err_q  <= 1'b0;
      simkill_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      reason_q   <= reason_d;
      mode_q     <= mode_d;
      timeout_q  <= timeout_d;
      num_q      <= num_d;
      sessions_q <= sessions_d;
      idle_q     <= idle_d;
      drain_q    <= drain_d;
      cfg_err_q  <= cfg_err_d;
      simkill_q  <= (state_q == StKill);
    end
  end

  assign simkill_req   = simkill_q;
  assign kill_reason   = reason_q;
  assign sessions_done = sessions_q;
  assign cfg_err       = cfg_err_q;
  assign state_o       = state_q;

endmodule
